// File: rtl/retire_watch_monitor.sv
// retire_watch_monitor: debug monitor that snoops the hart retire port.
//   It keeps shadow copies of up to NUM_WATCH architectural registers, the
//   retired-instruction count, the last retired PC and the halt status.
//   A registered, slice-selectable LED word shows any of these on a narrow LED bank.
// Optional build macro: MONITOR_TRACE_EN adds a TRACE_DEPTH-entry ring of {rd, data}.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_retire_valid/_halt/_rd_waddr/_rd_wdata/_pc   retire snoop
//   i_sel, i_slice, i_trace_idx    display source, LED slice, trace entry (0 = newest)
//   i_freeze, i_clear              hold captured state / synchronous clear
//   o_led                          registered LED word (previous-edge state)
//   o_halted, o_retire_count, o_trace_count   status
module retire_watch_monitor #(
  parameter int                     NUM_WATCH   = 2,
  parameter logic [5*NUM_WATCH-1:0] WATCH_REGS  = 10'h14B,
  parameter int                     LED_WIDTH   = 10,
  parameter int                     TRACE_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_retire_valid,
  input  logic                 i_retire_halt,
  input  logic [4:0]           i_retire_rd_waddr,
  input  logic [31:0]          i_retire_rd_wdata,
  input  logic [31:0]          i_retire_pc,
  input  logic [3:0]           i_sel,
  input  logic [1:0]           i_slice,
  input  logic                 i_freeze,
  input  logic                 i_clear,
  input  logic [5:0]           i_trace_idx,
  output logic [LED_WIDTH-1:0] o_led,
  output logic                 o_halted,
  output logic [31:0]          o_retire_count,
  output logic [6:0]           o_trace_count
);

  localparam logic [3:0] SEL_CNT = 4'(NUM_WATCH);
  localparam logic [3:0] SEL_PC  = 4'(NUM_WATCH + 1);
  localparam logic [3:0] SEL_TRC = 4'(NUM_WATCH + 2);

  logic [31:0]          r_shadow [NUM_WATCH];
  logic [31:0]          r_count;
  logic [31:0]          r_last_pc;
  logic                 r_halted;
  logic [LED_WIDTH-1:0] r_led;

  logic                 w_cap;
  logic                 w_rd_nz;
  logic [NUM_WATCH-1:0] w_hit;
  logic [31:0]          w_trace_word;
  logic [31:0]          w_word;
  logic [127:0]         w_ext;

  // A halted core ignores further retires until clear; freeze drops them outright.
  assign w_cap   = i_retire_valid & ~r_halted & ~i_freeze;
  assign w_rd_nz = (i_retire_rd_waddr != 5'd0);

  // x0 is never shadowed, even when listed as a watch index.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NUM_WATCH; k++) begin
      w_hit[k] = w_rd_nz && (WATCH_REGS[5*k +: 5] == i_retire_rd_waddr);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_WATCH; k++) r_shadow[k] <= '0;
      r_count   <= '0;
      r_last_pc <= '0;
      r_halted  <= 1'b0;
    end else if (i_clear) begin
      for (int k = 0; k < NUM_WATCH; k++) r_shadow[k] <= '0;
      r_count   <= '0;
      r_last_pc <= '0;
      r_halted  <= 1'b0;
    end else if (w_cap) begin
      for (int k = 0; k < NUM_WATCH; k++) begin
        if (w_hit[k]) r_shadow[k] <= i_retire_rd_wdata;
      end
      if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
      r_last_pc <= i_retire_pc;
      // The halting instruction itself is captured; everything after is ignored.
      if (i_retire_halt) r_halted <= 1'b1;
    end
  end

`ifdef MONITOR_TRACE_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);

  logic [31:0]      r_trace_dat [TRACE_DEPTH];
  logic [4:0]       r_trace_rd  [TRACE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [6:0]       r_trace_cnt;
  logic [PTR_W-1:0] w_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_trace_cnt <= '0;
    end else if (i_clear) begin
      r_wr_ptr    <= '0;
      r_trace_cnt <= '0;
    end else if (w_cap && w_rd_nz) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (r_trace_cnt != 7'(TRACE_DEPTH)) r_trace_cnt <= r_trace_cnt + 7'd1;
    end
  end

  // Ring contents need no reset: entries beyond the valid count are never shown.
  always_ff @(posedge i_clk) begin
    if (!i_clear && w_cap && w_rd_nz) begin
      r_trace_dat[r_wr_ptr] <= i_retire_rd_wdata;
      r_trace_rd[r_wr_ptr]  <= i_retire_rd_waddr;
    end
  end

  // Newest entry sits just below the write pointer; wrap is free in PTR_W bits.
  assign w_rd_ptr      = r_wr_ptr - PTR_W'(1) - i_trace_idx[PTR_W-1:0];
  assign w_trace_word  = ({1'b0, i_trace_idx} < r_trace_cnt) ? r_trace_dat[w_rd_ptr] : 32'd0;
  assign o_trace_count = r_trace_cnt;
`else
  logic w_unused_trace;
  assign w_unused_trace = ^{i_trace_idx, TRACE_DEPTH[0]};
  assign w_trace_word   = 32'd0;
  assign o_trace_count  = 7'd0;
`endif

  always_comb begin
    w_word = 32'd0;
    for (int k = 0; k < NUM_WATCH; k++) begin
      if (i_sel == 4'(k)) w_word = r_shadow[k];
    end
    if (i_sel == SEL_CNT) w_word = r_count;
    if (i_sel == SEL_PC)  w_word = r_last_pc;
    if (i_sel == SEL_TRC) w_word = w_trace_word;
  end

  // Zero-extended to 128 bits so slices reaching past bit 31 read as 0.
  assign w_ext = {96'd0, w_word} >> (32'(i_slice) * 32'(LED_WIDTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_led <= '0;
    else          r_led <= w_ext[LED_WIDTH-1:0];
  end

  assign o_led          = r_led;
  assign o_halted       = r_halted;
  assign o_retire_count = r_count;

endmodule

// File: tb/tb_retire_watch_monitor.sv
module tb_retire_watch_monitor;
  localparam int NW = 4;
  localparam int LW = 10;
  localparam int TD = 4;
  // ch0 = x11, ch1 = x10, ch2 = x0, ch3 = x11 (duplicate of ch0)
  localparam logic [5*NW-1:0] WR = {5'd11, 5'd0, 5'd10, 5'd11};
  int wr_idx[NW] = '{11, 10, 0, 11};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, halt, freeze, clear;
  logic [4:0]    rd;
  logic [31:0]   data, pc;
  logic [3:0]    sel;
  logic [1:0]    slice;
  logic [5:0]    tidx;
  logic [LW-1:0] led;
  logic          halted;
  logic [31:0]   rcount;
  logic [6:0]    tcount;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [31:0]   m_sh[NW];
  logic [31:0]   m_cnt, m_pc;
  bit            m_halt;
  logic [LW-1:0] m_led;
  logic [31:0]   m_tq[$];

  retire_watch_monitor #(.NUM_WATCH(NW), .WATCH_REGS(WR), .LED_WIDTH(LW), .TRACE_DEPTH(TD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_retire_valid(valid), .i_retire_halt(halt),
    .i_retire_rd_waddr(rd), .i_retire_rd_wdata(data), .i_retire_pc(pc),
    .i_sel(sel), .i_slice(slice), .i_freeze(freeze), .i_clear(clear), .i_trace_idx(tidx),
    .o_led(led), .o_halted(halted), .o_retire_count(rcount), .o_trace_count(tcount));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_word(input logic [3:0] s, input logic [5:0] idx);
    if (int'(s) < NW) return m_sh[int'(s)];
    if (int'(s) == NW) return m_cnt;
    if (int'(s) == NW + 1) return m_pc;
`ifdef MONITOR_TRACE_EN
    if (int'(s) == NW + 2) return (int'(idx) < m_tq.size()) ? m_tq[int'(idx)] : 32'd0;
`endif
    return 32'd0;
  endfunction

  function automatic logic [LW-1:0] m_led_of(input logic [3:0] s, input logic [1:0] sl, input logic [5:0] idx);
    logic [63:0] w;
    w = {32'd0, m_word(s, idx)} >> (int'(sl) * LW);
    return w[LW-1:0];
  endfunction

  function automatic logic [31:0] m_tcount();
`ifdef MONITOR_TRACE_EN
    return 32'(m_tq.size());
`else
    return 32'd0;
`endif
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NW; k++) m_sh[k] = 32'd0;
    m_cnt = 32'd0; m_pc = 32'd0; m_halt = 1'b0; m_led = '0;
    m_tq.delete();
  endtask

  // One clock edge: advance the reference with the inputs held across it, then compare.
  task automatic tick();
    logic [LW-1:0] nl;
    @(posedge clk);
    nl = m_led_of(sel, slice, tidx);
    if (clear) begin
      for (int k = 0; k < NW; k++) m_sh[k] = 32'd0;
      m_cnt = 32'd0; m_pc = 32'd0; m_halt = 1'b0;
      m_tq.delete();
    end else if (valid && !m_halt && !freeze) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      m_pc = pc;
      for (int k = 0; k < NW; k++) if (rd != 5'd0 && wr_idx[k] == int'(rd)) m_sh[k] = data;
      if (rd != 5'd0) begin
        m_tq.push_front(data);
        if (m_tq.size() > TD) void'(m_tq.pop_back());
      end
      if (halt) m_halt = 1'b1;
    end
    m_led = nl;
    #1;
    check_val("model_led", 32'(led), 32'(m_led));
    check_val("model_halted", 32'(halted), 32'(m_halt));
    check_val("model_count", rcount, m_cnt);
    check_val("model_tcount", 32'(tcount), m_tcount());
  endtask

  task automatic retire(input logic h, input logic [4:0] r, input logic [31:0] d);
    valid = 1'b1; halt = h; rd = r; data = d; pc = $urandom;
    tick();
    valid = 1'b0; halt = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] sl_exp[4];
    sl_exp = '{10'h000, 10'h3FF, 10'h3FF, 10'h003};
    rst_n = 1'b0; valid = 0; halt = 0; freeze = 0; clear = 0;
    rd = '0; data = '0; pc = '0; sel = '0; slice = '0; tidx = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_led", 32'(led), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_count", rcount, 32'd0);
    check_val("rst_tcount", 32'(tcount), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // basic capture and two-edge latency
    retire(1'b0, 5'd11, 32'h2AB);
    check_val("lat_led_early", 32'(led), 32'd0);
    tick();
    check_val("ch0_led", 32'(led), 32'h2AB);
    check_val("ch0_count", rcount, 32'd1);

    // slice selection on ch1
    retire(1'b0, 5'd10, 32'hFFFF_FC00);
    for (int s = 0; s < 4; s++) begin
      sel = 4'd1; slice = 2'(s);
      tick();
      check_val("slice_led", 32'(led), 32'(sl_exp[s]));
    end
    slice = 2'd0;

    // x0 is never shadowed
    retire(1'b0, 5'd0, 32'd5);
    sel = 4'd2;
    tick();
    check_val("x0_led", 32'(led), 32'd0);
    check_val("x0_count", rcount, 32'd3);

    // halt, then ignored retire, then clear
    sel = 4'd0;
    retire(1'b1, 5'd11, 32'd7);
    retire(1'b0, 5'd11, 32'd9);
    tick();
    check_val("halt_led", 32'(led), 32'd7);
    check_val("halt_flag", 32'(halted), 32'd1);
    check_val("halt_count", rcount, 32'd4);
    sel = 4'd3;
    tick();
    check_val("dup_led", 32'(led), 32'd7);
    clear = 1'b1; tick(); clear = 1'b0; tick();
    check_val("clr_led", 32'(led), 32'd0);
    check_val("clr_halted", 32'(halted), 32'd0);
    check_val("clr_count", rcount, 32'd0);

    // clear beats retire; freeze drops retire
    sel = 4'd0;
    clear = 1'b1; retire(1'b0, 5'd11, 32'd3); clear = 1'b0;
    tick();
    check_val("clrret_led", 32'(led), 32'd0);
    check_val("clrret_count", rcount, 32'd0);
    freeze = 1'b1; retire(1'b0, 5'd11, 32'd3); freeze = 1'b0;
    tick();
    check_val("frz_led", 32'(led), 32'd0);
    check_val("frz_count", rcount, 32'd0);

    // trace source
    for (int i = 1; i <= 6; i++) retire(1'b0, 5'd11, 32'(i));
    sel = 4'(NW + 2); tidx = 6'd0;
    tick();
`ifdef MONITOR_TRACE_EN
    check_val("trc_count", 32'(tcount), 32'd4);
    check_val("trc_idx0", 32'(led), 32'd6);
    tidx = 6'd3; tick();
    check_val("trc_idx3", 32'(led), 32'd3);
    tidx = 6'd4; tick();
    check_val("trc_idx4", 32'(led), 32'd0);
`else
    check_val("trc_off_led", 32'(led), 32'd0);
    check_val("trc_off_count", 32'(tcount), 32'd0);
`endif

    // randomized traffic against the reference
    for (int n = 0; n < 1500; n++) begin
      valid  = ($urandom_range(0, 3) != 0);
      halt   = ($urandom_range(0, 31) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      clear  = ($urandom_range(0, 23) == 0);
      case ($urandom_range(0, 4))
        0: rd = 5'd0;
        1: rd = 5'd10;
        2, 3: rd = 5'd11;
        default: rd = 5'($urandom);
      endcase
      data  = $urandom;
      pc    = $urandom;
      sel   = 4'($urandom_range(0, 9));
      slice = 2'($urandom);
      tidx  = 6'($urandom_range(0, 6));
      tick();

      // asynchronous reset between edges
      if (n == 700) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_led", 32'(led), 32'd0);
        check_val("arst_halted", 32'(halted), 32'd0);
        check_val("arst_count", rcount, 32'd0);
        check_val("arst_tcount", 32'(tcount), 32'd0);
        m_reset();
        @(negedge clk) rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/retire_watch_monitor.md
Name: retire_watch_monitor

Overview:
- Parametrised debug monitor for the board top level; successor to the single-register LED capture.
- Snoops the hart retire interface and keeps shadow copies of up to NUM_WATCH architectural registers.
- Also tracks retired-instruction count, last retired PC and halt status.
- Drives a registered, slice-selectable LED word so any watched value can be viewed on a narrow LED bank.

Parameters:
- NUM_WATCH, 2: number of watched registers (1..8).
- WATCH_REGS, 10'h14B: packed 5-bit register indices; channel k = WATCH_REGS[5k+4:5k]. Default: ch0 = x11 (a1), ch1 = x10 (a0).
- LED_WIDTH, 10: width of the LED output (1..32).
- TRACE_DEPTH, 16: trace ring entries; power of two, 2..64. Only used with MONITOR_TRACE_EN.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_retire_valid  in  1  one instruction retires this cycle
- i_retire_halt  in  1  retiring instruction is a halt
- i_retire_rd_waddr  in  5  destination register of retiring instruction
- i_retire_rd_wdata  in  32  value written to rd
- i_retire_pc  in  32  PC of retiring instruction
- i_sel  in  4  display source select
- i_slice  in  2  LED slice select
- i_freeze  in  1  hold all captured state
- i_clear  in  1  synchronous clear of captured state
- i_trace_idx  in  6  trace entry to display; 0 = most recent
- o_led  out  LED_WIDTH  displayed bits, registered
- o_halted  out  1  halt has retired
- o_retire_count  out  32  retired-instruction count
- o_trace_count  out  7  valid trace entries

Behaviour:
- Reset (i_rst_n low, asynchronous): all shadows, count, last PC, trace pointers and o_led = 0; o_halted = 0; o_trace_count = 0.
- Capture enable: cap = i_retire_valid & ~o_halted & ~i_freeze.
- On cap:
  - retire count +1, saturating at 32'hFFFF_FFFF.
  - last PC <= i_retire_pc.
  - every channel k with WATCH_REGS[k] == i_retire_rd_waddr and i_retire_rd_waddr != 0 loads i_retire_rd_wdata. Duplicate indices update all matching channels.
- Writes to x0 never update any shadow, even if x0 is listed in WATCH_REGS.
- Halt: on cap with i_retire_halt = 1, that instruction's own write and count are captured, then o_halted <= 1 next cycle. All later retires are ignored until clear or reset.
- i_freeze = 1: no state changes except o_led refresh; retires during freeze are lost, not queued.
- i_clear = 1: next edge zeroes shadows, count, last PC, o_halted and trace. Clear beats a simultaneous retire, and also applies while frozen.
- Source word W by i_sel:
  - 0..NUM_WATCH-1: shadow channel
  - NUM_WATCH: retire count
  - NUM_WATCH+1: last PC
  - NUM_WATCH+2: trace entry data (see feature)
  - any other value: 0
- Slice: o_led <= W[i_slice*LED_WIDTH +: LED_WIDTH]; bits above bit 31 read as 0.
- Latency: o_led is registered; it reflects i_sel/i_slice and state as of the previous edge. A captured retire is visible on o_led 2 edges after its retire cycle.

Optional Feature:
- MONITOR_TRACE_EN defined: TRACE_DEPTH-entry ring of {rd, data}.
  - Written on every cap with rd != 0.
  - Write pointer wraps modulo TRACE_DEPTH, overwriting the oldest entry.
  - o_trace_count saturates at TRACE_DEPTH.
  - i_sel = NUM_WATCH+2 shows data of entry i_trace_idx (0 = newest).
  - Display is 0 if i_trace_idx >= o_trace_count.
- Not defined: no ring storage; o_trace_count tied 0; i_sel = NUM_WATCH+2 reads 0.

Test Plan:
- Reset then retire rd=11, data=0x2AB; sel=0, slice=0 -> o_led = 10'h2AB two edges later; o_retire_count = 1.
- Retire rd=10, data=0xFFFF_FC00; sel=1, slices 0..3 -> o_led = 0x000, 0x3FF, 0x3FF, 0x003.
- Retire rd=0, data=5, with WATCH_REGS ch0 = 0 -> ch0 stays 0; count = 1.
- Retire halt with rd=11, data=7, then retire rd=11, data=9 -> ch0 = 7; o_halted = 1; count = 1; then i_clear -> all 0, o_halted = 0.
- Same-cycle i_clear and retire rd=11, data=3 -> ch0 = 0, count = 0. With i_freeze, retire rd=11 -> no change.
- MONITOR_TRACE_EN, TRACE_DEPTH=4: retire rd=11 with data 1..6 -> o_trace_count = 4; idx0 = 6; idx3 = 3; idx4 -> 0. Without macro, sel=NUM_WATCH+2 -> o_led = 0.
- Async reset asserted mid-stream between edges -> all outputs 0 immediately.
